integer_square_rebuild: RTL
===========================

# integer_square_rebuild

- Sequential inverse of the square-root unit: takes a root `r` and remainder `m` and rebuilds the radicand `a = r*r + m`.
- Uses a valid/ready handshake on both sides and a shift-and-add multiplier that processes one root bit per cycle.
- Sits after the square-root pipeline in the precision library, for self-check, and anywhere a radicand must be rebuilt without DSP multipliers.

## Interface
- WIDTH, 32, radicand width; must be even and ≥ 4
- clk  in  1  clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- in_valid  in  1  input operands valid
- in_ready  out  1  block can accept operands
- in_root  in  WIDTH/2  root r
- in_rem  in  WIDTH/2+1  remainder m
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_a  out  WIDTH  r*r + m, truncated to WIDTH bits
- out_err  out  1  m > 2*r (not a legal sqrt remainder) or sum overflowed WIDTH bits

## Operation
- FSM states and transitions:
  - IDLE → BUSY on input accept.
  - BUSY → DONE when the bit counter reaches WIDTH/2-1.
  - DONE → IDLE on output accept.
- Output decodes: `in_ready` = (state==IDLE); `out_valid` = (state==DONE).
- Accept edge (`in_valid && in_ready`) loads:
  - acc ← zero-extend(in_rem) to WIDTH+1 bits
  - mcand ← zero-extend(in_root) to WIDTH bits
  - mplier ← in_root
  - cnt ← 0
  - err_rem ← (in_rem > {in_root,1'b0})
  - state ← BUSY
- Each BUSY edge:
  - if mplier[0]: acc ← acc + mcand
  - mcand ← mcand << 1; mplier ← mplier >> 1; cnt ← cnt + 1
  - if cnt == WIDTH/2-1: state ← DONE
- DONE outputs:
  - out_a = acc[WIDTH-1:0]
  - out_err = err_rem | acc[WIDTH]
  - Both held stable while out_valid && !out_ready.
- Arithmetic:
  - acc is WIDTH+1 bits.
  - Maximum possible sum is exactly 2^WIDTH (r = 2^(W/2)-1, m = 2^(W/2+1)-1), so acc never wraps; acc[WIDTH] is the only overflow indication.
- The result is computed even when err_rem is set; the error is reported, not suppressed.
- In IDLE, inputs are ignored unless in_valid. in_root/in_rem need only be stable on the accept edge.
- Reset values: state=IDLE, in_ready=1 after reset, out_valid=0, out_a=0, out_err=0, acc/mcand/mplier/cnt=0.
- Reset mid-operation (BUSY or DONE): the transaction is dropped, no output is produced, and the block is back in IDLE on the next cycle.
- in_valid while BUSY/DONE: not accepted. The upstream source must hold the operands until in_ready.

## Timing
- Latency: out_valid rises exactly WIDTH/2 cycles after the accept edge (16 for WIDTH=32).
- The output transfer completes on an edge where out_valid && out_ready.
- in_ready rises the cycle after the output transfer. There is no same-cycle input/output overlap.
- Best-case throughput is one result per WIDTH/2+2 cycles.
- out_ready may be held high permanently. DONE then lasts exactly one cycle.
- No combinational path from any input to any output. All outputs decode from registers.
- Critical path is one WIDTH+1-bit adder.

## Structure
- Shared package `precision_pkg` holds:
  - the state enum `sq_state_t` {IDLE, BUSY, DONE}
  - the function `sqrt_rem_legal(root, rem)`, reused by the sqrt-unit benches
- Sub-module `shift_add_step`: combinational single-step acc/mcand/mplier update, parameterized by WIDTH, instantiated once.
- Counter width is $clog2(WIDTH/2).

## Test plan
- root=0, rem=0 → out_a=0, out_err=0, out_valid exactly 16 cycles after the accept edge.
- root=3, rem=5 → out_a=14, out_err=0.
- root=3, rem=7 → out_a=16, out_err=1 (7 > 6).
- root=0xFFFF, rem=0x1FFFE → out_a=0xFFFFFFFF, out_err=0.
- root=0xFFFF, rem=0x1FFFF → out_a=0, out_err=1 (overflow).
- Backpressure: hold out_ready=0 for 10 cycles with root=0x1234, rem=0 → out_a=0x014B5A90 stable and in_ready=0 throughout; accept on release, then in_ready=1 the next cycle.
- Reset asserted on BUSY cycle 5 → out_valid never asserts, in_ready=1 the cycle after reset deasserts, and the next transaction (root=2, rem=1 → 5) is correct.
- Random: 10k legal pairs fed through the sqrt unit then this block → out_a equals the original radicand, out_err=0.

Source files
------------

// File: rtl/precision_pkg.sv
// Shared definitions for the precision library: sqrt/rebuild FSM states and
// the legality rule for a square-root remainder.
package precision_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sq_state_t;

    // Widest root the helper handles; narrower roots are zero-extended by callers.
    localparam int SQ_MAX_ROOT_W = 32;

    // A remainder m is legal for root r when m <= 2*r, i.e. r*r + m < (r+1)^2.
    function automatic logic sqrt_rem_legal(input logic [SQ_MAX_ROOT_W-1:0] root,
                                            input logic [SQ_MAX_ROOT_W:0]   rem);
        return rem <= {root, 1'b0};
    endfunction

endpackage

// File: rtl/integer_square_rebuild_shift_add_step.sv
// One shift-and-add multiplication step: conditionally add the multiplicand,
// then move to the next multiplier bit.
module shift_add_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]       i_acc,
    input  logic [WIDTH-1:0]     i_mcand,
    input  logic [WIDTH/2-1:0]   i_mplier,
    output logic [WIDTH:0]       o_acc,
    output logic [WIDTH-1:0]     o_mcand,
    output logic [WIDTH/2-1:0]   o_mplier
);

    always_comb begin
        o_acc    = i_mplier[0] ? (i_acc + {1'b0, i_mcand}) : i_acc;
        o_mcand  = i_mcand << 1;
        o_mplier = i_mplier >> 1;
    end

endmodule

// File: rtl/integer_square_rebuild.sv
// Rebuilds a radicand a = r*r + m from a square root and its remainder using a
// bit-serial shift-and-add multiplier, one root bit per cycle.
module integer_square_rebuild
    import precision_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH/2-1:0] in_root,
    input  logic [WIDTH/2:0]   in_rem,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_a,
    output logic               out_err,
    output sq_state_t          o_dbg_state
);

    localparam int HW = WIDTH / 2;
    localparam int CW = $clog2(HW);

    // Handshake: a transfer happens on any rising edge where valid && ready;
    // in_ready is high only in IDLE, out_valid only in DONE, both registered.
    sq_state_t          r_state;
    sq_state_t          w_state_nxt;
    logic [WIDTH:0]     r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [HW-1:0]      r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_err_rem;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH:0]     w_acc_nxt;
    logic [WIDTH-1:0]   w_mcand_nxt;
    logic [HW-1:0]      w_mplier_nxt;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_cnt == CW'(HW - 1));

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = BUSY;
            BUSY:    if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    shift_add_step #(.WIDTH(WIDTH)) u_step (
        .i_acc    (r_acc),
        .i_mcand  (r_mcand),
        .i_mplier (r_mplier),
        .o_acc    (w_acc_nxt),
        .o_mcand  (w_mcand_nxt),
        .o_mplier (w_mplier_nxt)
    );

    // The remainder is preloaded into the accumulator, so the product lands on top of it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_err_rem <= 1'b0;
        end else if (w_accept) begin
            r_acc     <= (WIDTH + 1)'(in_rem);
            r_mcand   <= WIDTH'(in_root);
            r_mplier  <= in_root;
            r_cnt     <= '0;
            r_err_rem <= !sqrt_rem_legal(SQ_MAX_ROOT_W'(in_root), (SQ_MAX_ROOT_W + 1)'(in_rem));
        end else if (r_state == BUSY) begin
            r_acc     <= w_acc_nxt;
            r_mcand   <= w_mcand_nxt;
            r_mplier  <= w_mplier_nxt;
            r_cnt     <= r_cnt + 1'b1;
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign out_a       = out_valid ? r_acc[WIDTH-1:0] : '0;
    assign out_err     = out_valid & (r_err_rem | r_acc[WIDTH]);
    assign o_dbg_state = r_state;

endmodule
